hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller that drives the stall and flush controls of the ID/EX pipeline buffer, and the PC and IF/ID write enables. It detects load-use hazards, taken branches and multi-cycle EX operations. It then produces the capture/hold (`id_ex_halt`) and active-low clear (`id_ex_flush`) signals consumed by `id_ex_buff`. It sits in the decode stage between the register-field decode, the EX-stage branch/ALU logic and the pipeline registers.

## Interface
- `MULDIV_CYCLES`, default 4: total stall cycles for a multi-cycle EX op (1..7).
- `BR_FLUSH_CYCLES`, default 2: total cycles ID/EX is cleared after a taken branch (1..7).

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_rs`  in  4  source register A of the instruction in ID.
- `id_rt`  in  4  source register B of the instruction in ID.
- `id_uses_rt`  in  1  ID instruction reads `id_rt`.
- `ex_rd`  in  4  destination register of the instruction in EX.
- `ex_mem_read`  in  1  EX instruction is a load.
- `branch_taken`  in  1  branch resolved taken in EX (single-cycle pulse).
- `ex_muldiv`  in  1  multi-cycle op entered EX (single-cycle start pulse).
- `pc_write`  out  1  1 = PC updates.
- `if_id_write`  out  1  1 = IF/ID captures.
- `if_id_flush`  out  1  active-high clear of IF/ID.
- `id_ex_halt`  out  1  1 = ID/EX captures new inputs; 0 = ID/EX holds.
- `id_ex_flush`  out  1  active-low; 0 clears ID/EX to 16'h0000.
- `stall_count`  out  16  saturating count of cycles with `pc_write` = 0.

## Operation
- **FSM states:** RUN, MD_STALL, BR_FLUSH. There is also a 3-bit down-counter `cnt`.
- **Outputs are combinational** from the state and current inputs. State, `cnt` and `stall_count` are registered.
- **Normal (RUN, no hazard):** `pc_write`=1, `if_id_write`=1, `if_id_flush`=0, `id_ex_halt`=1, `id_ex_flush`=1.
- **Load-use hazard (RUN):** raised when `ex_mem_read` && `ex_rd`≠0 && (`ex_rd`==`id_rs` || (`id_uses_rt` && `ex_rd`==`id_rt`)).
  - Outputs: `pc_write`=0, `if_id_write`=0, `id_ex_flush`=0 (bubble), `id_ex_halt`=1.
  - Next state RUN. Exactly one bubble per occurrence.
- **Multi-cycle op (RUN, `ex_muldiv`=1):**
  - Outputs: `pc_write`=0, `if_id_write`=0, `id_ex_halt`=0, `id_ex_flush`=1.
  - If `MULDIV_CYCLES`>1: `cnt`←`MULDIV_CYCLES`-1 and go to MD_STALL. Otherwise stay in RUN.
- **MD_STALL:** same outputs as the multi-cycle entry cycle.
  - `cnt` decrements each cycle.
  - When `cnt`==1, next state is RUN.
  - `branch_taken`, `ex_muldiv` and load-use are ignored.
- **Taken branch (RUN, `branch_taken`=1):**
  - Outputs: `pc_write`=1 (target load), `if_id_write`=1, `if_id_flush`=1, `id_ex_halt`=1, `id_ex_flush`=0.
  - If `BR_FLUSH_CYCLES`>1: `cnt`←`BR_FLUSH_CYCLES`-1 and go to BR_FLUSH. Otherwise stay in RUN.
- **BR_FLUSH:** `id_ex_flush`=0 and `if_id_flush`=0; other outputs at normal values.
  - `cnt` decrements; when `cnt`==1, next state is RUN.
  - All hazard inputs are ignored.
- **Priority in RUN:** `branch_taken` > `ex_muldiv` > load-use. A lower-priority hazard coinciding with a higher one is dropped; its instruction is squashed or re-detected next cycle.
- **`stall_count`:** +1 on each clock edge where `rst`=0 and `pc_write`=0. It holds at 16'hFFFF (no wrap).

## Timing
- **Hazard response latency:** zero cycles. Outputs respond in the same cycle the inputs present the hazard.
- **Load-use:** exactly 1 cycle with `pc_write`=0.
- **Multi-cycle op:** exactly `MULDIV_CYCLES` consecutive cycles with `pc_write`=0 and `id_ex_halt`=0, starting with the pulse cycle.
- **Taken branch:** exactly `BR_FLUSH_CYCLES` consecutive cycles with `id_ex_flush`=0, starting with the pulse cycle. `if_id_flush` is high in the first of those cycles only.
- **While `rst`=1:**
  - Outputs: `pc_write`=0, `if_id_write`=0, `if_id_flush`=1, `id_ex_halt`=0, `id_ex_flush`=0.
  - On the edge: state←RUN, `cnt`←0, `stall_count`←0.
  - `stall_count` does not increment during reset.
- **Reset mid-MD_STALL or mid-BR_FLUSH:** abandons the sequence. The first cycle after reset deasserts is RUN with normal outputs.
- **`ex_rd`==0:** never causes a load-use stall (R0 is constant).

## Test plan
- **Reset:** `rst`=1 for 2 cycles, then release with no hazards → during reset `id_ex_flush`=0, `id_ex_halt`=0, `pc_write`=0; first post-reset cycle all normal; `stall_count`=0.
- **Load-use:** `ex_mem_read`=1, `ex_rd`=3, `id_rs`=3 for 1 cycle → that cycle `pc_write`=0, `id_ex_flush`=0, `id_ex_halt`=1; next cycle normal; `stall_count`=1. Repeat with `ex_rd`=0 → no stall. Repeat with `id_rt`=3 and `id_uses_rt`=0 → no stall.
- **Multi-cycle op:** `ex_muldiv` pulse at default `MULDIV_CYCLES`=4 → 4 cycles of `pc_write`=0 and `id_ex_halt`=0; a `branch_taken` pulse in cycle 3 is ignored; `stall_count` +4.
- **Taken branch:** `branch_taken` pulse at `BR_FLUSH_CYCLES`=2 → 2 cycles of `id_ex_flush`=0; `if_id_flush`=1 in the first cycle only; `pc_write`=1 throughout.
- **Simultaneous events:** `branch_taken`, `ex_muldiv` and a load-use hazard in the same cycle → branch behaviour only; no stall cycles.
- **Reset mid-stall, then saturation:** `rst` asserted in cycle 2 of MD_STALL → RUN after release. Force 65540 stall cycles → `stall_count` holds at 16'hFFFF.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Decode-stage hazard controller: load-use bubbles, multi-cycle EX stalls and
// taken-branch flushes driving PC, IF/ID and ID/EX buffer controls.
module hazard_ctrl #(
    parameter int unsigned MULDIV_CYCLES   = 4,
    parameter int unsigned BR_FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_rs,
    input  logic [3:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic [3:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        branch_taken,
    input  logic        ex_muldiv,
    output logic        pc_write,
    output logic        if_id_write,
    output logic        if_id_flush,
    output logic        id_ex_halt,
    output logic        id_ex_flush,
    output logic [15:0] stall_count
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned SC_W  = 16;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_STALL = 2'd1,
        BR_FLUSH = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             load_use;

    // R0 is hard-wired zero, so a load targeting it never creates a dependency
    assign load_use = ex_mem_read && (ex_rd != 4'd0) &&
                      ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pc_write    = 1'b1;
        if_id_write = 1'b1;
        if_id_flush = 1'b0;
        id_ex_halt  = 1'b1;
        id_ex_flush = 1'b1;
        if (rst) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            if_id_flush = 1'b1;
            id_ex_halt  = 1'b0;
            id_ex_flush = 1'b0;
            state_nxt   = RUN;
            cnt_nxt     = '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b0;
                        if (BR_FLUSH_CYCLES > 1) begin
                            cnt_nxt   = CNT_W'(BR_FLUSH_CYCLES - 1);
                            state_nxt = BR_FLUSH;
                        end
                    end else if (ex_muldiv) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_halt  = 1'b0;
                        if (MULDIV_CYCLES > 1) begin
                            cnt_nxt   = CNT_W'(MULDIV_CYCLES - 1);
                            state_nxt = MD_STALL;
                        end
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b0;
                    end
                end
                MD_STALL: begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_halt  = 1'b0;
                    cnt_nxt     = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state_nxt = RUN;
                end
                BR_FLUSH: begin
                    id_ex_flush = 1'b0;
                    cnt_nxt     = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) state_nxt = RUN;
                end
                default: begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Saturating count of frozen-PC cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (!pc_write && (stall_count != {SC_W{1'b1}})) begin
            stall_count <= stall_count + SC_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl; outputs are sampled #1 after
// input changes, well away from the rising edge.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rt, ex_mem_read, branch_taken, ex_muldiv;
    logic        pc_write, if_id_write, if_id_flush, id_ex_halt, id_ex_flush;
    logic [15:0] stall_count;
    logic [4:0]  outs;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [15:0] sc_exp;

    // {pc_write, if_id_write, if_id_flush, id_ex_halt, id_ex_flush}
    localparam logic [4:0] O_NORMAL = 5'b11011;
    localparam logic [4:0] O_RESET  = 5'b00100;
    localparam logic [4:0] O_LU     = 5'b00010;
    localparam logic [4:0] O_MD     = 5'b00001;
    localparam logic [4:0] O_BR1    = 5'b11110;
    localparam logic [4:0] O_BR2    = 5'b11010;

    always #5 clk = ~clk;

    assign outs = {pc_write, if_id_write, if_id_flush, id_ex_halt, id_ex_flush};

    hazard_ctrl #(.MULDIV_CYCLES(4), .BR_FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .branch_taken(branch_taken), .ex_muldiv(ex_muldiv),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_halt(id_ex_halt), .id_ex_flush(id_ex_flush),
        .stall_count(stall_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = 4'd0; id_rt = 4'd0; id_uses_rt = 1'b0; ex_rd = 4'd0;
        ex_mem_read = 1'b0; branch_taken = 1'b0; ex_muldiv = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        #1;
        total_cnt++;
        if (outs !== O_RESET) $display("FAIL reset_outs: got %b expected %b", outs, O_RESET);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (stall_count !== 16'd0) $display("FAIL reset_count: got %0d expected 0", stall_count);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if (outs !== O_NORMAL) $display("FAIL post_reset_outs: got %b expected %b", outs, O_NORMAL);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (stall_count !== 16'd0) $display("FAIL post_reset_count: got %0d expected 0", stall_count);
        else pass_cnt++;
        sc_exp = 16'd0;
    endtask

    task automatic test_load_use();
        ex_mem_read = 1'b1; ex_rd = 4'd3; id_rs = 4'd3;
        #1;
        total_cnt++;
        if (outs !== O_LU) $display("FAIL lu_rs_outs: got %b expected %b", outs, O_LU);
        else pass_cnt++;
        tick();
        clear_inputs();
        #1;
        sc_exp = sc_exp + 16'd1;
        total_cnt++;
        if (outs !== O_NORMAL) $display("FAIL lu_after_outs: got %b expected %b", outs, O_NORMAL);
        else pass_cnt++;
        total_cnt++;
        if (stall_count !== sc_exp) $display("FAIL lu_count: got %0d expected %0d", stall_count, sc_exp);
        else pass_cnt++;
        ex_mem_read = 1'b1; ex_rd = 4'd0; id_rs = 4'd0;
        #1;
        total_cnt++;
        if (outs !== O_NORMAL) $display("FAIL lu_r0_outs: got %b expected %b", outs, O_NORMAL);
        else pass_cnt++;
        tick();
        ex_rd = 4'd3; id_rs = 4'd5; id_rt = 4'd3; id_uses_rt = 1'b0;
        #1;
        total_cnt++;
        if (outs !== O_NORMAL) $display("FAIL lu_rt_unused_outs: got %b expected %b", outs, O_NORMAL);
        else pass_cnt++;
        tick();
        id_uses_rt = 1'b1;
        #1;
        total_cnt++;
        if (outs !== O_LU) $display("FAIL lu_rt_used_outs: got %b expected %b", outs, O_LU);
        else pass_cnt++;
        tick();
        clear_inputs();
        #1;
        sc_exp = sc_exp + 16'd1;
        total_cnt++;
        if (stall_count !== sc_exp) $display("FAIL lu_rt_count: got %0d expected %0d", stall_count, sc_exp);
        else pass_cnt++;
    endtask

    task automatic test_muldiv();
        for (int i = 0; i < 4; i++) begin
            ex_muldiv    = (i == 0);
            branch_taken = (i == 2);
            #1;
            total_cnt++;
            if (outs !== O_MD) $display("FAIL md_cycle%0d_outs: got %b expected %b", i, outs, O_MD);
            else pass_cnt++;
            tick();
        end
        clear_inputs();
        #1;
        sc_exp = sc_exp + 16'd4;
        total_cnt++;
        if (outs !== O_NORMAL) $display("FAIL md_after_outs: got %b expected %b", outs, O_NORMAL);
        else pass_cnt++;
        total_cnt++;
        if (stall_count !== sc_exp) $display("FAIL md_count: got %0d expected %0d", stall_count, sc_exp);
        else pass_cnt++;
    endtask

    task automatic test_branch();
        branch_taken = 1'b1;
        #1;
        total_cnt++;
        if (outs !== O_BR1) $display("FAIL br_cycle0_outs: got %b expected %b", outs, O_BR1);
        else pass_cnt++;
        tick();
        // hazards in the flush shadow must be ignored
        branch_taken = 1'b0; ex_mem_read = 1'b1; ex_rd = 4'd7; id_rs = 4'd7; ex_muldiv = 1'b1;
        #1;
        total_cnt++;
        if (outs !== O_BR2) $display("FAIL br_cycle1_outs: got %b expected %b", outs, O_BR2);
        else pass_cnt++;
        tick();
        clear_inputs();
        #1;
        total_cnt++;
        if (outs !== O_NORMAL) $display("FAIL br_after_outs: got %b expected %b", outs, O_NORMAL);
        else pass_cnt++;
        total_cnt++;
        if (stall_count !== sc_exp) $display("FAIL br_count: got %0d expected %0d", stall_count, sc_exp);
        else pass_cnt++;
    endtask

    task automatic test_simultaneous();
        branch_taken = 1'b1; ex_muldiv = 1'b1;
        ex_mem_read = 1'b1; ex_rd = 4'd3; id_rs = 4'd3;
        #1;
        total_cnt++;
        if (outs !== O_BR1) $display("FAIL sim_cycle0_outs: got %b expected %b", outs, O_BR1);
        else pass_cnt++;
        tick();
        clear_inputs();
        #1;
        total_cnt++;
        if (outs !== O_BR2) $display("FAIL sim_cycle1_outs: got %b expected %b", outs, O_BR2);
        else pass_cnt++;
        tick();
        #1;
        total_cnt++;
        if (outs !== O_NORMAL) $display("FAIL sim_after_outs: got %b expected %b", outs, O_NORMAL);
        else pass_cnt++;
        total_cnt++;
        if (stall_count !== sc_exp) $display("FAIL sim_count: got %0d expected %0d", stall_count, sc_exp);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_stall();
        ex_muldiv = 1'b1;
        tick();
        ex_muldiv = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        total_cnt++;
        if (outs !== O_RESET) $display("FAIL mid_rst_outs: got %b expected %b", outs, O_RESET);
        else pass_cnt++;
        tick();
        rst = 1'b0;
        #1;
        total_cnt++;
        if (outs !== O_NORMAL) $display("FAIL mid_rst_release_outs: got %b expected %b", outs, O_NORMAL);
        else pass_cnt++;
        total_cnt++;
        if (stall_count !== 16'd0) $display("FAIL mid_rst_count: got %0d expected 0", stall_count);
        else pass_cnt++;
        tick();
        #1;
        total_cnt++;
        if (outs !== O_NORMAL) $display("FAIL mid_rst_run_outs: got %b expected %b", outs, O_NORMAL);
        else pass_cnt++;
    endtask

    task automatic test_saturation();
        ex_mem_read = 1'b1; ex_rd = 4'd3; id_rs = 4'd3;
        repeat (65534) tick();
        total_cnt++;
        if (stall_count !== 16'hFFFE) $display("FAIL sat_near_count: got %h expected fffe", stall_count);
        else pass_cnt++;
        repeat (6) tick();
        total_cnt++;
        if (stall_count !== 16'hFFFF) $display("FAIL sat_count: got %h expected ffff", stall_count);
        else pass_cnt++;
        total_cnt++;
        if (outs !== O_LU) $display("FAIL sat_outs: got %b expected %b", outs, O_LU);
        else pass_cnt++;
        clear_inputs();
        tick();
        total_cnt++;
        if (stall_count !== 16'hFFFF) $display("FAIL sat_hold_count: got %h expected ffff", stall_count);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_muldiv();
        test_branch();
        test_simultaneous();
        test_reset_mid_stall();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
